// File: rtl/seq_mul_pkg.sv
// Shared types and helpers for the seq_mul_hs handshaked sequential multiplier.
package seq_mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } seq_mul_state_e;

    // Width of a counter that can hold values 0..w.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/seq_mul_ctrl.sv
// FSM, bit counter and handshake outputs for seq_mul_hs; drives load/step/fix strobes.
// SEQ_MUL_HS_EARLY_TERM_EN: leave CALC once the shifted multiplier is empty.
module seq_mul_ctrl
    import seq_mul_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic src_valid_i,
    input  logic dest_ready_i,
`ifdef SEQ_MUL_HS_EARLY_TERM_EN
    input  logic mult_empty_i,
`endif
    output logic src_ready_o,
    output logic dest_valid_o,
    output logic load_o,
    output logic step_o,
    output logic fix_o
);

    localparam int CNT_W = cnt_width(WIDTH);

    seq_mul_state_e   state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             calc_exit;

`ifdef SEQ_MUL_HS_EARLY_TERM_EN
    assign calc_exit = (cnt_q == CNT_W'(WIDTH - 1)) || mult_empty_i;
`else
    assign calc_exit = (cnt_q == CNT_W'(WIDTH - 1));
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        // NOTE: every output gets a default first, so no path can infer a latch.
        state_d      = state_q;
        cnt_d        = cnt_q;
        load_o       = 1'b0;
        step_o       = 1'b0;
        fix_o        = 1'b0;
        src_ready_o  = (state_q == IDLE);
        dest_valid_o = (state_q == DONE);
        case (state_q)
            IDLE: begin
                if (src_valid_i) begin
                    load_o  = 1'b1;
                    cnt_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                step_o = 1'b1;
                cnt_d  = cnt_q + CNT_W'(1);
                if (calc_exit) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                fix_o   = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                if (dest_ready_i) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

endmodule

// File: rtl/seq_mul_hs.sv
// Parametrised shift-add multiplier, signed/unsigned per transaction, valid/ready on both sides.
// SEQ_MUL_HS_EARLY_TERM_EN: shortens CALC when the remaining multiplier bits are all zero.
module seq_mul_hs
    import seq_mul_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               src_valid,
    output logic               src_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               is_signed,
    output logic               dest_valid,
    input  logic               dest_ready,
    output logic [2*WIDTH-1:0] product
);

    logic [2*WIDTH-1:0] mcand_q, acc_q, product_q;
    logic [WIDTH-1:0]   mult_q;
    logic               sign_q;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic               load, step, fix;

    // -2^(WIDTH-1) negates to itself, which reads correctly as the unsigned magnitude.
    assign a_mag = (is_signed && a[WIDTH-1]) ? -a : a;
    assign b_mag = (is_signed && b[WIDTH-1]) ? -b : b;

`ifdef SEQ_MUL_HS_EARLY_TERM_EN
    logic mult_empty;
    assign mult_empty = (mult_q[WIDTH-1:1] == '0);
`endif

    seq_mul_ctrl #(.WIDTH(WIDTH)) u_ctrl (
        .clk          (clk),
        .reset        (reset),
        .src_valid_i  (src_valid),
        .dest_ready_i (dest_ready),
`ifdef SEQ_MUL_HS_EARLY_TERM_EN
        .mult_empty_i (mult_empty),
`endif
        .src_ready_o  (src_ready),
        .dest_valid_o (dest_valid),
        .load_o       (load),
        .step_o       (step),
        .fix_o        (fix)
    );

    always_ff @(posedge clk) begin
        // NOTE: non-blocking updates, so each register sees the pre-edge values of the others.
        if (reset) begin
            mcand_q   <= '0;
            mult_q    <= '0;
            acc_q     <= '0;
            sign_q    <= 1'b0;
            product_q <= '0;
        end else begin
            if (load) begin
                mcand_q <= {{WIDTH{1'b0}}, a_mag};
                mult_q  <= b_mag;
                acc_q   <= '0;
                sign_q  <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            end
            if (step) begin
                if (mult_q[0]) begin
                    acc_q <= acc_q + mcand_q;
                end
                mcand_q <= mcand_q << 1;
                mult_q  <= mult_q >> 1;
            end
            if (fix) begin
                product_q <= sign_q ? -acc_q : acc_q;
            end
        end
    end

    assign product = product_q;

endmodule

// File: doc/seq_mul_hs.md
# seq_mul_hs

Parametrised sequential shift-add multiplier, successor to the 16-bit fixed signed sequential multiplier. It adds operand width `WIDTH`, a per-transaction signed/unsigned mode, and valid/ready handshakes on both input and result sides, so a producer and consumer can stall it. It sits between an operand-issuing controller and a result consumer in the arithmetic datapath.

## Interface
- `WIDTH`, default 16: operand width in bits, legal values 2 or more. `product` is 2*`WIDTH` bits.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: **synchronous, active-high reset.**
- `src_valid` input 1: operands and mode are valid.
- `src_ready` output 1: block accepts operands. High only in IDLE.
- `a` input `WIDTH`: multiplicand.
- `b` input `WIDTH`: multiplier.
- `is_signed` input 1: 1 means `a` and `b` are two's complement; 0 means unsigned.
- `dest_valid` output 1: `product` is valid.
- `dest_ready` input 1: consumer accepts `product`.
- `product` output 2*`WIDTH`: the result.

## Operation
- FSM states are IDLE, CALC, FIX and DONE.
- IDLE:
  - `src_ready`=1.
  - On `src_valid && src_ready`, capture `a`, `b` and `is_signed`; go to CALC.
  - At capture, operands are converted to magnitudes. The sign flag is `is_signed & (a[MSB]^b[MSB])`.
  - The magnitude of -2^(WIDTH-1) is 2^(WIDTH-1) and fits in `WIDTH` unsigned bits.
- CALC, one bit per cycle:
  - If mult_reg[0] is set, acc += mcand_reg. mcand_reg is 2*`WIDTH` bits.
  - Then mcand_reg <<= 1 and mult_reg >>= 1.
  - A bit counter counts `WIDTH` iterations, then the FSM goes to FIX.
- FIX: `product` = sign ? -acc : acc, using 2*`WIDTH`-bit two's complement. Go to DONE.
- DONE:
  - `dest_valid`=1 and `product` is held stable.
  - On `dest_valid && dest_ready`, go to IDLE.
  - No new operands are accepted in DONE.
- Inputs are sampled only at the accept edge. Changes to `a`, `b` or `is_signed` afterwards have no effect.
- `product` holds its last value until the next FIX. It is only meaningful while `dest_valid`=1.
- Reset values: state=IDLE, `src_ready`=1, `dest_valid`=0, `product`=0, and all internal registers 0.
- Reset mid-operation, in any state, aborts the transaction at the next edge. There is no result and no partial output.

## Timing
- Latency is counted from the accept edge to the edge after which `dest_valid`=1.
  - Without early termination: `WIDTH`+2 cycles (`WIDTH` CALC cycles plus 1 FIX cycle, then DONE).
- `src_ready` drops the cycle after accept. It returns the cycle after the `dest_ready` handshake edge.
- Minimum issue interval is latency + 1 cycle, with `dest_ready` held high.
- `dest_ready` high while the FSM is not in DONE is ignored.
- `src_valid` while `src_ready`=0 is ignored. The producer must hold its operands until `src_ready`.

## Configuration
- Macro: `SEQ_MUL_HS_EARLY_TERM_EN`.
- Defined:
  - CALC exits to FIX on the edge where the updated mult_reg becomes 0.
  - Minimum is one CALC cycle, so `b`=0 gives latency 3.
  - In general, latency = max(1, index of the highest set bit of |b| + 1) + 2.
  - Results are identical to the undefined build.
- Undefined: the CALC duration is always exactly `WIDTH` cycles, and latency is fixed at `WIDTH`+2.

## Structure
- `seq_mul_pkg` holds:
  - the state enum typedef `seq_mul_state_e` (IDLE, CALC, FIX, DONE);
  - a function returning the counter width, `$clog2(WIDTH+1)`.
- One sub-module, `seq_mul_ctrl`, holds the FSM, the bit counter and the handshake outputs. It drives load, step and fix strobes to the datapath in `seq_mul_hs`.
- Datapath registers: mcand_reg (2*`WIDTH`), mult_reg (`WIDTH`), acc (2*`WIDTH`), sign flag.

## Test plan
All scenarios use `WIDTH`=16 with `dest_ready`=1 unless stated otherwise.
1. Signed 15 × 3 -> `product`=45. `dest_valid` rises 18 cycles after accept in the undefined build, 4 cycles with the macro defined.
2. Signed -5 × 7 -> 32'hFFFF_FFDD (-35). Signed 8 × -4 -> -32. Signed -6 × -5 -> 30.
3. Corner cases:
   - Unsigned 16'hFFFF × 16'hFFFF -> 32'hFFFE_0001.
   - Signed 16'h8000 × 16'h8000 -> 32'h4000_0000.
   - Signed 16'h8000 × 1 -> 32'hFFFF_8000.
   - Any `a` × 0 -> 0.
4. Backpressure:
   - Hold `dest_ready`=0 for 10 cycles in DONE; `product` and `dest_valid` stay stable and `src_ready`=0.
   - Toggle `a` and `b` during CALC; the result is unchanged.
5. Reset mid-operation: assert `reset` for 1 cycle during CALC. Next cycle `src_ready`=1, `dest_valid`=0 and `product`=0. A subsequent 3 × 4 returns 12.
6. Random soak: 1000 transactions with random `a`, `b`, `is_signed` and random `dest_ready` stalls. Each is checked against a reference model, signed or unsigned per `is_signed`.
